// File: rtl/core_run_ctrl_if.sv
// Signal bundle between the run controller and its environment: host load stream,
// IMEM write port, core reset/data-store monitor and status.
interface core_run_ctrl_if #(
  parameter int unsigned AW = 6
) ();
  logic          start;
  logic          load_valid;
  logic          load_ready;
  logic [31:0]   load_data;
  logic          load_last;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_reset;
  logic          MemWrite;
  logic [31:0]   DataAdr;
  logic [31:0]   WriteData;
  logic          busy;
  logic          done;
  logic          pass;
  logic [1:0]    fail_code;
  logic [31:0]   cycle_count;

  modport master (
    input  start, load_valid, load_data, load_last, MemWrite, DataAdr, WriteData,
    output load_ready, imem_we, imem_addr, imem_wdata, core_reset,
           busy, done, pass, fail_code, cycle_count
  );

  modport slave (
    output start, load_valid, load_data, load_last, MemWrite, DataAdr, WriteData,
    input  load_ready, imem_we, imem_addr, imem_wdata, core_reset,
           busy, done, pass, fail_code, cycle_count
  );
endinterface

// File: rtl/core_run_ctrl.sv
// Run controller for the RV32I core: loads IMEM from a host stream, releases the core
// from reset and turns its data-memory stores into a pass/fail/timeout verdict.
module core_run_ctrl #(
  parameter int unsigned IMEM_WORDS     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter logic [31:0] TOHOST_ADDR    = 32'd32,
  parameter logic [31:0] SCRATCH_ADDR   = 32'd16
) (
  input logic             clk,
  input logic             reset,
  core_run_ctrl_if.master bus
);
  localparam int unsigned AW = $clog2(IMEM_WORDS);

  typedef enum logic [2:0] {StIdle, StLoad, StHold, StRun, StDone} state_e;

  state_e        state_q;
  logic [AW-1:0] idx_q;
  logic          hold_q;
  logic          load_ready_q;
  logic          core_reset_q;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;
  logic [1:0]    fail_code_q;
  logic [31:0]   cycle_count_q;

  logic is_tohost;
  logic store_hit;
  logic last_word;
  logic timeout_hit;

  // Scratch stores are tolerated; every other store ends the run.
  always_comb begin
    is_tohost   = (bus.DataAdr == TOHOST_ADDR);
    store_hit   = bus.MemWrite && (is_tohost || (bus.DataAdr != SCRATCH_ADDR));
    last_word   = bus.load_last || (idx_q == AW'(IMEM_WORDS - 1));
    timeout_hit = (cycle_count_q == 32'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      hold_q        <= 1'b0;
      load_ready_q  <= 1'b0;
      core_reset_q  <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_code_q   <= 2'd0;
      cycle_count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            state_q       <= StLoad;
            idx_q         <= '0;
            load_ready_q  <= 1'b1;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_code_q   <= 2'd0;
            cycle_count_q <= '0;
          end
        end
        StLoad: begin
          if (bus.load_valid) begin
            if (last_word) begin
              // Index is left in place so it never wraps past the top word.
              state_q      <= StHold;
              load_ready_q <= 1'b0;
              hold_q       <= 1'b0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        StHold: begin
          hold_q <= 1'b1;
          if (hold_q) begin
            state_q       <= StRun;
            core_reset_q  <= 1'b0;
            cycle_count_q <= '0;
          end
        end
        StRun: begin
          if (store_hit || timeout_hit) begin
            state_q      <= StDone;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            // A classified store outranks the timeout in the same cycle.
            if (store_hit) begin
              if (is_tohost && (bus.WriteData == 32'd1)) begin
                pass_q <= 1'b1;
              end else if (is_tohost && (bus.WriteData == 32'd0)) begin
                fail_code_q <= 2'd1;
              end else begin
                fail_code_q <= 2'd2;
              end
            end else begin
              fail_code_q <= 2'd3;
            end
          end else begin
            cycle_count_q <= cycle_count_q + 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.load_ready  = load_ready_q;
  assign bus.imem_we     = load_ready_q && bus.load_valid;
  assign bus.imem_addr   = idx_q;
  assign bus.imem_wdata  = bus.load_data;
  assign bus.core_reset  = core_reset_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.fail_code   = fail_code_q;
  assign bus.cycle_count = cycle_count_q;
endmodule
